// File: rtl/beta_mem_arbiter.sv
// Shares one memory bus between instruction fetch, LSU read and LSU write.
// One transaction in flight; fixed priority wr > rd > if with a fetch anti-starvation window.
module beta_mem_arbiter #(
   parameter int DataWidth    = 32,
   parameter int AddressWidth = 32,
   parameter int MaxLsuBurst  = 4
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      if_req_i,
   input  logic [AddressWidth-1:0]   if_addr_i,
   output logic                      if_ready_o,
   output logic                      if_valid_o,
   output logic [DataWidth-1:0]      if_rdata_o,
   input  logic                      rd_req_i,
   input  logic [AddressWidth-1:0]   rd_addr_i,
   input  logic [DataWidth/8-1:0]    rd_strb_i,
   output logic                      rd_ready_o,
   output logic                      rd_valid_o,
   output logic [DataWidth-1:0]      rd_rdata_o,
   input  logic                      wr_req_i,
   input  logic [AddressWidth-1:0]   wr_addr_i,
   input  logic [DataWidth-1:0]      wr_data_i,
   input  logic [DataWidth/8-1:0]    wr_strb_i,
   output logic                      wr_ready_o,
   output logic                      wr_valid_o,
   output logic                      mem_req_o,
   output logic                      mem_we_o,
   output logic [AddressWidth-1:0]   mem_addr_o,
   output logic [DataWidth-1:0]      mem_wdata_o,
   output logic [DataWidth/8-1:0]    mem_strb_o,
   input  logic                      mem_ready_i,
   input  logic                      mem_valid_i,
   input  logic [DataWidth-1:0]      mem_rdata_i
);

   localparam int StrbWidth = DataWidth / 8;
   localparam int CntWidth  = $clog2(MaxLsuBurst + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_RD, OWN_WR} owner_t;

   state_t              state, state_nxt;
   owner_t              owner, grant;
   logic [CntWidth-1:0] lsu_cnt;
   logic                fetch_turn;
   logic                capture;
   logic                resp_fire;

   // Fetch overrides the fixed priority once the LSU has used its whole burst window.
   assign fetch_turn = if_req_i && (lsu_cnt == CntWidth'(MaxLsuBurst));

   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a default first,
      // otherwise an unassigned path infers a latch.
      grant = OWN_NONE;
      if (fetch_turn)    grant = OWN_IF;
      else if (wr_req_i) grant = OWN_WR;
      else if (rd_req_i) grant = OWN_RD;
      else if (if_req_i) grant = OWN_IF;
   end

   assign capture   = (state == ST_IDLE) && (grant != OWN_NONE);
   assign resp_fire = (state == ST_RESP) && mem_valid_i;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (capture)     state_nxt = ST_REQ;
         ST_REQ:  if (mem_ready_i) state_nxt = ST_RESP;
         ST_RESP: if (mem_valid_i) state_nxt = ST_IDLE;
         default:                  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      if_ready_o = 1'b0;
      rd_ready_o = 1'b0;
      wr_ready_o = 1'b0;
      if_valid_o = 1'b0;
      rd_valid_o = 1'b0;
      wr_valid_o = 1'b0;
      if_rdata_o = '0;
      rd_rdata_o = '0;
      mem_req_o  = (state == ST_REQ);
      if (capture) begin
         if_ready_o = (grant == OWN_IF);
         rd_ready_o = (grant == OWN_RD);
         wr_ready_o = (grant == OWN_WR);
      end
      if (resp_fire) begin
         case (owner)
            OWN_IF: begin if_valid_o = 1'b1; if_rdata_o = mem_rdata_i; end
            OWN_RD: begin rd_valid_o = 1'b1; rd_rdata_o = mem_rdata_i; end
            OWN_WR: wr_valid_o = 1'b1;
            default: ;
         endcase
      end
   end

   // Bus fields are latched once at capture so they stay stable under back-pressure.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         owner       <= OWN_NONE;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         mem_strb_o  <= '0;
      end else if (capture) begin
         owner <= grant;
         case (grant)
            OWN_WR: begin
               mem_we_o    <= 1'b1;
               mem_addr_o  <= wr_addr_i;
               mem_wdata_o <= wr_data_i;
               mem_strb_o  <= wr_strb_i;
            end
            OWN_RD: begin
               mem_we_o    <= 1'b0;
               mem_addr_o  <= rd_addr_i;
               mem_wdata_o <= '0;
               mem_strb_o  <= rd_strb_i;
            end
            default: begin
               mem_we_o    <= 1'b0;
               mem_addr_o  <= if_addr_i;
               mem_wdata_o <= '0;
               mem_strb_o  <= {StrbWidth{1'b1}};
            end
         endcase
      end
   end

   // Counts LSU grants that overtook a waiting fetch; saturates at the burst limit.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         lsu_cnt <= '0;
      end else if (capture) begin
         if (grant == OWN_IF || !if_req_i)              lsu_cnt <= '0;
         else if (lsu_cnt != CntWidth'(MaxLsuBurst))    lsu_cnt <= lsu_cnt + CntWidth'(1);
      end
   end

endmodule
